pipeline_hazard_ctrl: RTL

- Central stall/flush/forward scheduler for the 5-stage riscv_cpu pipeline.
- Drives the per-stage advance enables (FD/DE/EM/MW), the flush and bubble controls, and the EX-operand forwarding selects.
- Sequences multi-cycle multiply occupancy of EX and makes halt sticky.
- Sits beside the pipeline registers; consumes register addresses and control bits from D, E, M and W.

---
 rtl/pipeline_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush/forward scheduler for the 5-stage riscv_cpu pipeline.
//            Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              rs1_use_d,
    input  logic              rs2_use_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_wr_e,
    input  logic              load_e,
    input  logic              mul_e,
    input  logic              redirect_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_wr_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_wr_w,
    input  logic              halt_w,
    output logic              advance_fd,
    output logic              advance_de,
    output logic              advance_em,
    output logic              advance_mw,
    output logic              flush_fd,
    output logic              flush_de,
    output logic              bubble_de,
    output logic              bubble_em,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mul_busy,
`ifdef HAZARD_PERF_CNT_EN
    output logic              halted,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`else
    output logic              halted
`endif
);

    localparam int               c_CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MUL_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic               mul_done_q, mul_done_d;

    logic       w_load_use;
    logic       w_mul_start;
    logic       w_adv_fd, w_adv_de, w_adv_em, w_adv_mw;
    logic       w_flush_fd, w_flush_de, w_bubble_de, w_bubble_em;
    logic [1:0] w_fwd_a, w_fwd_b;

    function automatic logic [1:0] fwd_pick(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] dst_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] dst_w
    );
        if (wr_m && (dst_m != '0) && (dst_m == rs))
            return 2'b10;
        else if (wr_w && (dst_w != '0) && (dst_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_load_use = load_e && reg_wr_e && (rd_e != '0) &&
                        ((rs1_use_d && (rs1_d == rd_e)) || (rs2_use_d && (rs2_d == rd_e)));

    // mul_done_q keeps a finished mul from re-arming while it leaves EX
    assign w_mul_start = (MUL_LATENCY > 1) && mul_e && !mul_done_q;

    assign w_fwd_a = fwd_pick(rs1_e, reg_wr_m, rd_m, reg_wr_w, rd_w);
    assign w_fwd_b = fwd_pick(rs2_e, reg_wr_m, rd_m, reg_wr_w, rd_w);

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        mul_done_d  = 1'b0;
        w_adv_fd    = 1'b1;
        w_adv_de    = 1'b1;
        w_adv_em    = 1'b1;
        w_adv_mw    = 1'b1;
        w_flush_fd  = 1'b0;
        w_flush_de  = 1'b0;
        w_bubble_de = 1'b0;
        w_bubble_em = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect_e) begin
                    w_flush_fd = 1'b1;
                    w_flush_de = 1'b1;
                end else if (w_mul_start) begin
                    w_adv_fd    = 1'b0;
                    w_adv_de    = 1'b0;
                    w_adv_em    = 1'b0;
                    w_bubble_em = 1'b1;
                    mul_cnt_d   = c_CNT_LOAD;
                    state_d     = ST_MUL_WAIT;
                end else if (w_load_use) begin
                    w_adv_fd    = 1'b0;
                    w_bubble_de = 1'b1;
                end
                if (halt_w)
                    state_d = ST_HALTED;
            end
            ST_MUL_WAIT: begin
                w_adv_fd    = 1'b0;
                w_adv_de    = 1'b0;
                w_adv_em    = 1'b0;
                w_bubble_em = 1'b1;
                mul_cnt_d   = mul_cnt_q - c_CNT_ONE;
                if (mul_cnt_q == c_CNT_ONE) begin
                    state_d    = ST_RUN;
                    mul_done_d = 1'b1;
                end
                if (halt_w)
                    state_d = ST_HALTED;
            end
            ST_HALTED: begin
                w_adv_fd = 1'b0;
                w_adv_de = 1'b0;
                w_adv_em = 1'b0;
                w_adv_mw = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset overrides every combinational path, forwarding included
    always_comb begin
        advance_fd = 1'b0;
        advance_de = 1'b0;
        advance_em = 1'b0;
        advance_mw = 1'b0;
        flush_fd   = 1'b0;
        flush_de   = 1'b0;
        bubble_de  = 1'b0;
        bubble_em  = 1'b0;
        fwd_a_sel  = 2'b00;
        fwd_b_sel  = 2'b00;
        mul_busy   = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            advance_fd = w_adv_fd;
            advance_de = w_adv_de;
            advance_em = w_adv_em;
            advance_mw = w_adv_mw;
            flush_fd   = w_flush_fd;
            flush_de   = w_flush_de;
            bubble_de  = w_bubble_de;
            bubble_em  = w_bubble_em;
            fwd_a_sel  = w_fwd_a;
            fwd_b_sel  = w_fwd_b;
            mul_busy   = (state_q == ST_MUL_WAIT);
            halted     = (state_q == ST_HALTED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            mul_cnt_q  <= '0;
            mul_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            mul_done_q <= mul_done_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!w_adv_fd && (state_q != ST_HALTED) && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (w_flush_fd && (flush_events_q != 32'hFFFF_FFFF))
            flush_events_d = flush_events_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

    // Illegal pipeline combinations that upstream decode must never produce
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((state_q == ST_MUL_WAIT) && redirect_e));
            assert (!((state_q == ST_RUN) && load_e && mul_e));
        end
    end

endmodule
`default_nettype wire
